// File: rtl/time_base.sv
`default_nettype none
// ============================================================================
// Module      : time_base
// Description : BCD hh:mm:ss time base with set-time, display-hold and
//               alarm-edit modes, driven by a TICK_DIV-cycle prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module time_base #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        inc_hr,
    input  logic        inc_min,
    output logic [23:0] timebuffer,
    output logic        sec_tick,
    output logic        min_tick
);

    localparam int              c_PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TC         = c_PW'(TICK_DIV - 1);
    localparam logic [1:0]      c_MODE_RUN   = 2'b00;
    localparam logic [1:0]      c_MODE_SET   = 2'b01;
    localparam logic [1:0]      c_MODE_HOLD  = 2'b10;
    localparam logic [1:0]      c_MODE_ALARM = 2'b11;

    // Two-digit BCD increment for minutes/seconds, wrapping 59 -> 00.
    function automatic logic [7:0] f_inc_60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD increment for hours, wrapping 23 -> 00.
    function automatic logic [7:0] f_inc_hr(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)           r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [c_PW-1:0] r_presc;
    logic [7:0]      r_hr;
    logic [7:0]      r_min;
    logic [7:0]      r_sec;
    logic [7:0]      r_al_hr;
    logic [7:0]      r_al_min;
    logic [23:0]     r_tb;
    logic            r_sec_tick;
    logic            r_min_tick;

    logic [c_PW-1:0] w_presc_nxt;
    logic [7:0]      w_hr_nxt;
    logic [7:0]      w_min_nxt;
    logic [7:0]      w_sec_nxt;
    logic [7:0]      w_al_hr_nxt;
    logic [7:0]      w_al_min_nxt;
    logic [23:0]     w_tb_nxt;
    logic            w_sec_adv;
    logic            w_sec_wrap;

    always_comb begin
        w_presc_nxt  = r_presc;
        w_hr_nxt     = r_hr;
        w_min_nxt    = r_min;
        w_sec_nxt    = r_sec;
        w_al_hr_nxt  = r_al_hr;
        w_al_min_nxt = r_al_min;
        w_sec_adv    = 1'b0;
        w_sec_wrap   = 1'b0;

        if (mode == c_MODE_SET) begin
            // Setting parks the prescaler so the first second after exit is full length.
            w_presc_nxt = '0;
            w_sec_nxt   = 8'h00;
            if (inc_hr)  w_hr_nxt  = f_inc_hr(r_hr);
            if (inc_min) w_min_nxt = f_inc_60(r_min);
        end else begin
            if (r_presc == c_TC) begin
                w_presc_nxt = '0;
                w_sec_adv   = 1'b1;
                w_sec_nxt   = f_inc_60(r_sec);
                if (r_sec == 8'h59) begin
                    w_sec_wrap = 1'b1;
                    w_min_nxt  = f_inc_60(r_min);
                    if (r_min == 8'h59) w_hr_nxt = f_inc_hr(r_hr);
                end
            end else begin
                w_presc_nxt = r_presc + c_PW'(1);
            end
            if (mode == c_MODE_ALARM) begin
                if (inc_hr)  w_al_hr_nxt  = f_inc_hr(r_al_hr);
                if (inc_min) w_al_min_nxt = f_inc_60(r_al_min);
            end
        end
    end

    // Display follows the post-edge state so it tracks live registers exactly.
    always_comb begin
        w_tb_nxt = r_tb;
        case (mode)
            c_MODE_RUN:   w_tb_nxt = {w_hr_nxt, w_min_nxt, w_sec_nxt};
            c_MODE_SET:   w_tb_nxt = {w_hr_nxt, w_min_nxt, 8'h00};
            c_MODE_HOLD:  w_tb_nxt = r_tb;
            c_MODE_ALARM: w_tb_nxt = {w_al_hr_nxt, w_al_min_nxt, 8'h00};
            default:      w_tb_nxt = r_tb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_hr       <= 8'h00;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_al_hr    <= 8'h00;
            r_al_min   <= 8'h00;
            r_tb       <= 24'h000000;
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_hr       <= w_hr_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_al_hr    <= w_al_hr_nxt;
            r_al_min   <= w_al_min_nxt;
            r_tb       <= w_tb_nxt;
            r_sec_tick <= w_sec_adv;
            r_min_tick <= w_sec_wrap;
        end
    end

    assign timebuffer = r_tb;
    assign sec_tick   = r_sec_tick;
    assign min_tick   = r_min_tick;

endmodule
`default_nettype wire

// File: tb/tb_time_base.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_base
// Description : Self-checking bench for time_base against a seconds-of-day model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_base;

    localparam int TICK_DIV = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic        inc_hr  = 1'b0;
    logic        inc_min = 1'b0;
    logic [23:0] timebuffer;
    logic        sec_tick;
    logic        min_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: live time as seconds-of-day, alarm as plain integers.
    int          m_sod;
    int          m_ah;
    int          m_am;
    int          m_presc;
    logic [23:0] m_tb;
    logic        m_st;
    logic        m_mt;

    time_base #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .inc_hr     (inc_hr),
        .inc_min    (inc_min),
        .timebuffer (timebuffer),
        .sec_tick   (sec_tick),
        .min_tick   (min_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic logic [23:0] disp(input int h, input int m, input int s);
        return {to_bcd(h), to_bcd(m), to_bcd(s)};
    endfunction

    task automatic model_reset();
        m_sod = 0; m_ah = 0; m_am = 0; m_presc = 0;
        m_tb = 24'h0; m_st = 1'b0; m_mt = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] md, input logic ih, input logic im);
        int h;
        int mi;
        m_st = 1'b0;
        m_mt = 1'b0;
        if (md == 2'b01) begin
            h  = (m_sod / 3600 + (ih ? 1 : 0)) % 24;
            mi = ((m_sod / 60) % 60 + (im ? 1 : 0)) % 60;
            m_sod   = h * 3600 + mi * 60;
            m_presc = 0;
        end else begin
            if (m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                m_st    = 1'b1;
                m_mt    = (m_sod % 60 == 59);
                m_sod   = (m_sod + 1) % 86400;
            end else begin
                m_presc++;
            end
            if (md == 2'b11) begin
                m_ah = (m_ah + (ih ? 1 : 0)) % 24;
                m_am = (m_am + (im ? 1 : 0)) % 60;
            end
        end
        case (md)
            2'b00:   m_tb = disp(m_sod / 3600, (m_sod / 60) % 60, m_sod % 60);
            2'b01:   m_tb = disp(m_sod / 3600, (m_sod / 60) % 60, 0);
            2'b11:   m_tb = disp(m_ah, m_am, 0);
            default: m_tb = m_tb;
        endcase
    endtask

    // One clock with the given inputs; leaves time at posedge+1 for sampling.
    task automatic step(input logic [1:0] md, input logic ih, input logic im);
        mode    = md;
        inc_hr  = ih;
        inc_min = im;
        @(posedge clk);
        model_edge(md, ih, im);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mode = 2'b00; inc_hr = 1'b0; inc_min = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        mode = 2'b01; inc_hr = 1'b1; inc_min = 1'b1;
        #1;
        n_tests++;
        if (timebuffer !== 24'h0 || sec_tick !== 1'b0 || min_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got tb=%h st=%b mt=%b want 000000/0/0", timebuffer, sec_tick, min_tick);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mode = 2'b00; inc_hr = 1'b0; inc_min = 1'b0; rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 8; i++) begin
            step(2'b00, 1'b0, 1'b0);
            n_tests++;
            if (sec_tick !== ((i % 4) == 0) || timebuffer !== m_tb) begin
                n_fail++;
                $display("FAIL first_tick edge %0d got st=%b tb=%h want st=%b tb=%h",
                         i, sec_tick, timebuffer, ((i % 4) == 0), m_tb);
            end
        end
        n_tests++;
        if (timebuffer !== 24'h000002) begin
            n_fail++;
            $display("FAIL reset_run got %h want 000002", timebuffer);
        end
    endtask

    task automatic test_minute();
        int st_cnt = 0;
        int mt_cnt = 0;
        do_reset();
        for (int i = 0; i < 240; i++) begin
            step(2'b00, 1'b0, 1'b0);
            st_cnt += sec_tick ? 1 : 0;
            mt_cnt += min_tick ? 1 : 0;
            n_tests++;
            if (timebuffer !== m_tb || sec_tick !== m_st || min_tick !== m_mt) begin
                n_fail++;
                $display("FAIL minute_cycle %0d got %h/%b/%b want %h/%b/%b",
                         i, timebuffer, sec_tick, min_tick, m_tb, m_st, m_mt);
            end
        end
        n_tests++;
        if (st_cnt != 60 || mt_cnt != 1 || timebuffer !== 24'h000100) begin
            n_fail++;
            $display("FAIL minute_total got st=%0d mt=%0d tb=%h want 60/1/000100", st_cnt, mt_cnt, timebuffer);
        end
    endtask

    task automatic test_set_time();
        int ticks = 0;
        do_reset();
        for (int i = 0; i < 83; i++) begin
            if (i < 23)      step(2'b01, 1'b1, 1'b0);
            else if (i < 82) step(2'b01, 1'b0, 1'b1);
            else             step(2'b01, 1'b1, 1'b1);
            ticks += (sec_tick || min_tick) ? 1 : 0;
            n_tests++;
            if (timebuffer !== m_tb) begin
                n_fail++;
                $display("FAIL set_cycle %0d got %h want %h", i, timebuffer, m_tb);
            end
            if (i == 81) begin
                n_tests++;
                if (timebuffer !== 24'h235900) begin
                    n_fail++;
                    $display("FAIL set_2359 got %h want 235900", timebuffer);
                end
            end
        end
        n_tests++;
        if (timebuffer !== 24'h000000 || ticks != 0) begin
            n_fail++;
            $display("FAIL set_wrap got tb=%h ticks=%0d want 000000/0", timebuffer, ticks);
        end
    endtask

    task automatic test_midnight();
        do_reset();
        repeat (23) step(2'b01, 1'b1, 1'b0);
        repeat (59) step(2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 232; i++) begin
            step(2'b00, 1'b0, 1'b0);
            n_tests++;
            if (timebuffer !== m_tb || sec_tick !== m_st || min_tick !== m_mt) begin
                n_fail++;
                $display("FAIL mid_run %0d got %h/%b/%b want %h/%b/%b",
                         i, timebuffer, sec_tick, min_tick, m_tb, m_st, m_mt);
            end
        end
        n_tests++;
        if (timebuffer !== 24'h235958) begin
            n_fail++;
            $display("FAIL mid_235958 got %h want 235958", timebuffer);
        end
        for (int i = 1; i <= 8; i++) begin
            step(2'b00, 1'b0, 1'b0);
            n_tests++;
            if ((i == 4 && (timebuffer !== 24'h235959 || min_tick !== 1'b0)) ||
                (i == 8 && (timebuffer !== 24'h000000 || min_tick !== 1'b1)) ||
                timebuffer !== m_tb || min_tick !== m_mt) begin
                n_fail++;
                $display("FAIL mid_wrap edge %0d got tb=%h mt=%b want tb=%h mt=%b",
                         i, timebuffer, min_tick, m_tb, m_mt);
            end
        end
    endtask

    task automatic test_alarm();
        do_reset();
        repeat (10) step(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 37; i++) begin
            step(2'b11, (i < 7), (i >= 7));
            n_tests++;
            if (timebuffer !== m_tb || sec_tick !== m_st) begin
                n_fail++;
                $display("FAIL alarm_cycle %0d got %h/%b want %h/%b", i, timebuffer, sec_tick, m_tb, m_st);
            end
        end
        n_tests++;
        if (timebuffer !== 24'h073000) begin
            n_fail++;
            $display("FAIL alarm_edit got %h want 073000", timebuffer);
        end
        step(2'b00, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h000012 || timebuffer !== m_tb) begin
            n_fail++;
            $display("FAIL alarm_live got %h want 000012", timebuffer);
        end
        step(2'b11, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h073000) begin
            n_fail++;
            $display("FAIL alarm_retain got %h want 073000", timebuffer);
        end
    endtask

    task automatic test_hold();
        int st_cnt = 0;
        do_reset();
        repeat (20) step(2'b00, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h000005) begin
            n_fail++;
            $display("FAIL hold_entry got %h want 000005", timebuffer);
        end
        for (int i = 0; i < 40; i++) begin
            step(2'b10, (i % 3) == 0, (i % 5) == 0);
            st_cnt += sec_tick ? 1 : 0;
            n_tests++;
            if (timebuffer !== 24'h000005 || sec_tick !== m_st || min_tick !== m_mt) begin
                n_fail++;
                $display("FAIL hold_cycle %0d got %h/%b want 000005/%b", i, timebuffer, sec_tick, m_st);
            end
        end
        n_tests++;
        if (st_cnt != 10) begin
            n_fail++;
            $display("FAIL hold_ticks got %0d want 10", st_cnt);
        end
        step(2'b00, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h000015 || timebuffer !== m_tb) begin
            n_fail++;
            $display("FAIL hold_exit got %h want 000015", timebuffer);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (12) step(2'b01, 1'b1, 1'b0);
        repeat (34) step(2'b01, 1'b0, 1'b1);
        repeat (224) step(2'b00, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h123456) begin
            n_fail++;
            $display("FAIL areset_setup got %h want 123456", timebuffer);
        end
        step(2'b11, 1'b1, 1'b0);
        step(2'b11, 1'b0, 1'b1);
        mode = 2'b11; inc_hr = 1'b1; inc_min = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (timebuffer !== 24'h0 || sec_tick !== 1'b0 || min_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_mid got tb=%h st=%b mt=%b want 000000/0/0", timebuffer, sec_tick, min_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(2'b11, 1'b0, 1'b0);
        n_tests++;
        if (timebuffer !== 24'h000000) begin
            n_fail++;
            $display("FAIL areset_alarm got %h want 000000", timebuffer);
        end
        repeat (3) step(2'b00, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (sec_tick !== 1'b0 || timebuffer !== 24'h0) begin
            n_fail++;
            $display("FAIL areset_tick got st=%b tb=%h want 0/000000", sec_tick, timebuffer);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [1:0] md = 2'b00;
        int         hold = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (hold <= 0) begin
                md   = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 25);
            end
            hold--;
            step(md, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            n_tests++;
            if (timebuffer !== m_tb || sec_tick !== m_st || min_tick !== m_mt) begin
                n_fail++;
                $display("FAIL random %0d mode=%b got %h/%b/%b want %h/%b/%b",
                         i, md, timebuffer, sec_tick, min_tick, m_tb, m_st, m_mt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_minute();
        test_set_time();
        test_midnight();
        test_alarm();
        test_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
